// File: rtl/unified_memory.sv
// Parametrised main memory for CPU_top: one CPU port with a configurable read
// pipeline and range checking, plus a valid/ready program-load port.
module unified_memory #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned RDW_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mar,
    input  logic [DATA_W-1:0] mbr_wdata,
    input  logic              wr_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              addr_err,
    input  logic              load_mode,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [ADDR_W:0]   ld_count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_dat [READ_LAT];
    logic [READ_LAT-1:0] r_vld;
    logic [READ_LAT-1:0] r_err;
    logic [CNT_W-1:0]    r_ld_count;

    logic              w_cpu_rng;
    logic              w_ld_rng;
    logic              w_cpu_wr;
    logic              w_ld_wr;
    logic [IDX_W-1:0]  w_cpu_idx;
    logic [IDX_W-1:0]  w_ld_idx;
    logic [DATA_W-1:0] w_rd_word;

    // Range checks written as if/else so an unknown address falls to out-of-range
    always_comb begin
        w_cpu_rng = 1'b0;
        w_ld_rng  = 1'b0;
        if ({1'b0, mar} < DEPTH_C) begin
            w_cpu_rng = 1'b1;
        end
        if ({1'b0, ld_addr} < DEPTH_C) begin
            w_ld_rng = 1'b1;
        end
    end

    assign w_cpu_idx = mar[IDX_W-1:0];
    assign w_ld_idx  = ld_addr[IDX_W-1:0];
    assign w_cpu_wr  = !load_mode && wr_en && w_cpu_rng;
    assign w_ld_wr   = load_mode && ld_valid && w_ld_rng;
    assign ld_ready  = load_mode;

    // Word returned for this cycle's access, including read-during-write policy
    always_comb begin
        w_rd_word = '0;
        if (w_cpu_rng) begin
            if ((RDW_MODE != 0) && w_cpu_wr) begin
                w_rd_word = mbr_wdata;
            end else begin
                w_rd_word = r_mem[w_cpu_idx];
            end
        end
    end

    // Array contents survive reset
    always_ff @(posedge clk) begin
        if (w_cpu_wr) begin
            r_mem[w_cpu_idx] <= mbr_wdata;
        end else if (w_ld_wr) begin
            r_mem[w_ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_err <= '0;
            for (int i = 0; i < int'(READ_LAT); i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= !load_mode;
            r_err[0] <= !load_mode && !w_cpu_rng;
            r_dat[0] <= load_mode ? '0 : w_rd_word;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_count <= '0;
        end else if (w_ld_wr && (r_ld_count != DEPTH_C)) begin
            r_ld_count <= r_ld_count + CNT_W'(1);
        end
    end

    assign rd_data  = r_dat[READ_LAT-1];
    assign rd_valid = r_vld[READ_LAT-1];
    assign addr_err = r_err[READ_LAT-1];
    assign ld_count = r_ld_count;

endmodule

// File: tb/tb_unified_memory.sv
// Bench for unified_memory: three configurations share one stimulus stream and
// are compared each cycle against a cycle-history reference model.
module tb_unified_memory;

    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 8;
    localparam int          NDUT = 3;
    localparam int          HMAX = 4096;

    typedef struct packed {
        logic          v;
        logic          e;
        logic [DW-1:0] d;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] mar;
    logic [DW-1:0] mbr_wdata;
    logic          wr_en;
    logic          load_mode;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    logic [DW-1:0] rd_data  [NDUT];
    logic          rd_valid [NDUT];
    logic          addr_err [NDUT];
    logic          ld_ready [NDUT];
    logic [AW:0]   ld_count [NDUT];

    acc_t          hist [NDUT][HMAX];
    logic [DW-1:0] mmem [NDUT][256];
    int            cnt  [NDUT];
    int            n;
    int            rst_mark;
    int            total;
    int            bad;

    always #5 clk = ~clk;

    unified_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .READ_LAT(1), .RDW_MODE(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .mar(mar), .mbr_wdata(mbr_wdata), .wr_en(wr_en),
        .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .addr_err(addr_err[0]),
        .load_mode(load_mode), .ld_valid(ld_valid), .ld_ready(ld_ready[0]),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_count(ld_count[0])
    );

    unified_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .READ_LAT(3), .RDW_MODE(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .mar(mar), .mbr_wdata(mbr_wdata), .wr_en(wr_en),
        .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .addr_err(addr_err[1]),
        .load_mode(load_mode), .ld_valid(ld_valid), .ld_ready(ld_ready[1]),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_count(ld_count[1])
    );

    unified_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(200), .READ_LAT(4), .RDW_MODE(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .mar(mar), .mbr_wdata(mbr_wdata), .wr_en(wr_en),
        .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .addr_err(addr_err[2]),
        .load_mode(load_mode), .ld_valid(ld_valid), .ld_ready(ld_ready[2]),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_count(ld_count[2])
    );

    function automatic int dep(input int k);
        return (k == 2) ? 200 : 256;
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic bit rdw(input int k);
        return (k == 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Output after edge n belongs to the access sampled at edge n-lat+1
    task automatic compare();
        for (int k = 0; k < NDUT; k++) begin
            int   j;
            acc_t x;
            j = n - lat(k) + 1;
            x = '0;
            if (j > rst_mark) x = hist[k][j];
            chk($sformatf("d%0d_rd_valid", k), 32'(rd_valid[k]), 32'(x.v));
            chk($sformatf("d%0d_addr_err", k), 32'(addr_err[k]), 32'(x.e));
            if (x.v) chk($sformatf("d%0d_rd_data", k), 32'(rd_data[k]), 32'(x.d));
            chk($sformatf("d%0d_ld_count", k), 32'(ld_count[k]), 32'(cnt[k]));
            chk($sformatf("d%0d_ld_ready", k), 32'(ld_ready[k]), 32'(load_mode));
        end
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        if (n >= HMAX) begin
            $display("FAIL step_budget observed=%0d limit=%0d", n, HMAX);
            $fatal(1, "cycle budget exhausted");
        end
        for (int k = 0; k < NDUT; k++) begin
            acc_t a;
            a = '0;
            if (rst_n && !load_mode) begin
                a.v = 1'b1;
                if (int'(mar) < dep(k)) a.d = (rdw(k) && wr_en) ? mbr_wdata : mmem[k][mar];
                else a.e = 1'b1;
            end
            hist[k][n] = a;
            if (!load_mode && wr_en && int'(mar) < dep(k)) mmem[k][mar] = mbr_wdata;
            if (load_mode && ld_valid && int'(ld_addr) < dep(k)) begin
                mmem[k][ld_addr] = ld_data;
                if (rst_n && cnt[k] < dep(k)) cnt[k]++;
            end
        end
        #1;
        compare();
    endtask

    task automatic rst_assert();
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        ld_valid = 1'b0;
        #1;
        rst_mark = n;
        for (int k = 0; k < NDUT; k++) begin
            cnt[k] = 0;
            chk($sformatf("d%0d_rst_valid", k), 32'(rd_valid[k]), 32'd0);
            chk($sformatf("d%0d_rst_err", k), 32'(addr_err[k]), 32'd0);
            chk($sformatf("d%0d_rst_count", k), 32'(ld_count[k]), 32'd0);
        end
    endtask

    task automatic load_word(input int a, input logic [DW-1:0] d);
        ld_valid = 1'b1;
        ld_addr  = AW'(a);
        ld_data  = d;
        step();
    endtask

    initial begin
        total = 0; bad = 0; n = 0; rst_mark = 0;
        for (int k = 0; k < NDUT; k++) begin
            cnt[k] = 0;
            for (int a = 0; a < 256; a++) mmem[k][a] = '0;
        end
        rst_n = 1'b1; mar = '0; mbr_wdata = '0; wr_en = 1'b0;
        load_mode = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        #2;
        rst_assert();
        step();
        step();
        rst_n = 1'b1;

        // Clear every word, then keep loading so ld_count saturates at DEPTH
        for (int i = 0; i < 300; i++) load_word(i % 256, 16'h0000);
        ld_valid = 1'b0;
        chk("sat_count_d0", 32'(ld_count[0]), 32'd256);
        chk("sat_count_d2", 32'(ld_count[2]), 32'd200);
        rst_assert();
        step();
        rst_n = 1'b1;

        // Program load
        load_word(0, 16'h0232);
        load_word(1, 16'h013C);
        load_word(2, 16'h0700);
        load_word(50, 16'h00AA);
        ld_valid = 1'b0;
        chk("prog_count_d0", 32'(ld_count[0]), 32'd4);
        chk("prog_count_d2", 32'(ld_count[2]), 32'd4);

        // First CPU access on the load_mode 1->0 edge
        load_mode = 1'b0;
        mar = 8'd50;
        step();
        chk("t1_data_d0", 32'(rd_data[0]), 32'h00AA);
        chk("t1_valid_d0", 32'(rd_valid[0]), 32'd1);

        // Back-to-back reads through the 3-stage configuration
        mar = 8'd0; step();
        mar = 8'd1; step();
        mar = 8'd2; step();
        chk("t2_word0_d1", 32'(rd_data[1]), 32'h0232);
        step();
        chk("t2_word1_d1", 32'(rd_data[1]), 32'h013C);
        step();
        chk("t2_word2_d1", 32'(rd_data[1]), 32'h0700);

        // Read during write to the same address
        wr_en = 1'b1; mar = 8'd60; mbr_wdata = 16'h00AA;
        step();
        chk("t3_old_d0", 32'(rd_data[0]), 32'h0000);
        wr_en = 1'b0;
        step();
        chk("t3_after_d0", 32'(rd_data[0]), 32'h00AA);
        step();
        chk("t3_new_d1", 32'(rd_data[1]), 32'h00AA);
        step();
        chk("t3_old_d2", 32'(rd_data[2]), 32'h0000);
        step();
        chk("t3_after_d2", 32'(rd_data[2]), 32'h00AA);

        // Out-of-range write and read for DEPTH=200
        wr_en = 1'b1; mar = 8'd255; mbr_wdata = 16'hBEEF;
        step();
        wr_en = 1'b0; mar = 8'd10;
        step(); step(); step();
        chk("t4_err_d2", 32'(addr_err[2]), 32'd1);
        chk("t4_data_d2", 32'(rd_data[2]), 32'h0000);
        step();
        chk("t4_err_clear_d2", 32'(addr_err[2]), 32'd0);
        load_mode = 1'b1;
        load_word(250, 16'h1234);
        ld_valid = 1'b0;
        chk("t4_drop_count_d2", 32'(ld_count[2]), 32'd4);
        chk("t4_keep_count_d0", 32'(ld_count[0]), 32'd5);

        // Reset while reads are in flight
        load_mode = 1'b0; mar = 8'd60;
        step();
        step();
        rst_assert();
        step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("t5_quiet_d2", 32'(rd_valid[2]), 32'd0);
        step();
        chk("t5_valid_d2", 32'(rd_valid[2]), 32'd1);
        chk("t5_persist_d2", 32'(rd_data[2]), 32'h00AA);

        // Random traffic including loader interleaving and range edges
        for (int i = 0; i < 500; i++) begin
            load_mode = ($urandom_range(0, 99) < 15);
            mar       = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(180, 255))
                                                    : AW'($urandom_range(0, 70));
            wr_en     = ($urandom_range(0, 2) == 0);
            mbr_wdata = DW'($urandom);
            ld_valid  = ($urandom_range(0, 1) == 1);
            ld_addr   = AW'($urandom_range(0, 255));
            ld_data   = DW'($urandom);
            step();
        end
        load_mode = 1'b1; ld_valid = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 5; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
